aes_gcm_round_stage: RTL and testbench
======================================

Name: aes_gcm_round_stage

Overview:
- Parametrised AES round pipeline stage for the AES-GCM datapath.
- Applies ROUNDS consecutive AES encryption rounds, starting at round FIRST_ROUND, to up to N_LANES independent 128-bit blocks per beat (e.g. H, CB, J0).
- Carries the key schedule, phase and sideband forward unchanged.
- Adds a valid/ready handshake with a one-entry skid buffer, per-lane enables and AES-128/192/256 support, so a chain of instances can form a stallable multi-lane pipeline.

Parameters:
- N_LANES, 3, number of 128-bit block lanes per beat.
- KEY_BITS, 128, AES key size: 128/192/256 gives NR = 10/12/14.
- FIRST_ROUND, 1, index of the first round applied, 0..NR.
- ROUNDS, 1, number of consecutive rounds applied, 1..NR+1-FIRST_ROUND.
- SIDE_W, 128, width of the opaque sideband (plain text/AAD/instance size are packed here by the user).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_valid  in  1  input beat valid
- o_ready  out  1  stage can accept a beat
- i_block  in  N_LANES*128  lane blocks, lane 0 at MSBs, [0:...] big-endian bit order
- i_lane_en  in  N_LANES  1 = apply rounds to the lane, 0 = pass the lane through unchanged
- i_key_schedule  in  128*(NR+1)  round keys; key r is bits [128*r : 128*r+127]
- i_phase  in  3  phase tag
- i_side  in  SIDE_W  sideband, passed through
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream accepts
- o_block  out  N_LANES*128  processed lanes
- o_lane_en, o_key_schedule, o_phase, o_side  out  widths as inputs  forwarded copies

Behaviour:
- Round 0 is AddRoundKey(key0) only.
- Round r in 1..NR-1 is SubBytes, ShiftRows, MixColumns, AddRoundKey(key r).
- Round NR omits MixColumns.
- Each enabled lane passes through rounds FIRST_ROUND..FIRST_ROUND+ROUNDS-1 in order; the round operations are combinational on the input beat.
- Disabled lanes are forwarded bit-exact.
- Transfer occurs when i_valid && o_ready.
- Output beat is taken when o_valid && i_ready.
- Output register (OR) plus one skid entry (SK).
- States:
  - EMPTY (OR and SK invalid).
  - ONE (OR valid).
  - FULL (OR and SK valid).
- Transitions:
  - EMPTY + accept -> ONE; o_valid rises the next cycle (latency 1 cycle).
  - ONE + accept + drain -> ONE, OR replaced.
  - ONE + accept, no drain -> FULL, beat stored in SK.
  - ONE + drain, no accept -> EMPTY.
  - FULL + drain -> ONE, SK moves to OR.
- o_ready = !SK_valid. It is registered: it depends only on state, never combinationally on i_ready.
- In FULL, i_valid is ignored (o_ready = 0). A drain in FULL makes o_ready = 1 the next cycle.
- While o_valid && !i_ready, every output is held stable.
- Beats leave in acceptance order; none is dropped or duplicated.
- Reset (any cycle, including mid-stall):
  - Next cycle: o_valid = 0, SK invalid, o_ready = 0 during the rst cycle and 1 from the first cycle after.
  - o_block, o_lane_en, o_key_schedule, o_phase, o_side = 0.
  - Beats in flight are discarded.
- Elaboration:
  - KEY_BITS must be 128, 192 or 256.
  - FIRST_ROUND+ROUNDS must be <= NR+1.
  - N_LANES must be >= 1.
  - Any violation is an elaboration error.

Test Plan:
- AES-128, FIRST_ROUND=0, ROUNDS=11, key 000102030405060708090a0b0c0d0e0f, lane0 00112233445566778899aabbccddeeff, lane_en=001 -> after 1 cycle o_block lane0 = 69c4e0d86a7b0430d8cdb78070b4c55a; lanes 1 and 2 equal their inputs.
- Same key, FIRST_ROUND=1, ROUNDS=1, lane0 00102030405060708090a0b0c0d0e0f0 -> 89d810e8855ace682d1843d8cb128fe4; o_phase, o_side and o_key_schedule equal the inputs.
- KEY_BITS=256, FIRST_ROUND=0, ROUNDS=15, key 000102..1f, pt 00112233..ff -> 8ea2b7ca516745bfeafc49904b496089.
- Backpressure: i_ready=0, push beats A, B -> o_ready=0 after B. Hold 5 cycles -> o_block stays A. Raise i_ready -> A then B delivered on consecutive cycles; o_ready returns to 1.
- Continuous streaming of 100 random beats with i_valid=i_ready=1 -> one output per cycle, in order, matching the software model.
- rst asserted while FULL -> next cycle o_valid=0 and all outputs 0; first cycle after release o_ready=1; no stale beat emerges.

Source files
------------

// File: rtl/aes_gcm_round_stage.sv
`default_nettype none
// ============================================================================
// Module   : aes_gcm_round_stage
// Brief    : Stallable multi-lane AES encryption round stage for the AES-GCM
//            datapath. Applies ROUNDS consecutive rounds starting at
//            FIRST_ROUND to every enabled 128-bit lane, forwards the key
//            schedule, phase and sideband, and registers the beat behind a
//            valid/ready handshake with a one-entry skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
module aes_gcm_round_stage #(
    parameter int N_LANES     = 3,
    parameter int KEY_BITS    = 128,
    parameter int FIRST_ROUND = 1,
    parameter int ROUNDS      = 1,
    parameter int SIDE_W      = 128
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_valid,
    output logic                           o_ready,
    input  logic [0:N_LANES*128-1]         i_block,
    input  logic [N_LANES-1:0]             i_lane_en,
    input  logic [0:128*(KEY_BITS/32+7)-1] i_key_schedule,
    input  logic [2:0]                     i_phase,
    input  logic [SIDE_W-1:0]              i_side,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [0:N_LANES*128-1]         o_block,
    output logic [N_LANES-1:0]             o_lane_en,
    output logic [0:128*(KEY_BITS/32+7)-1] o_key_schedule,
    output logic [2:0]                     o_phase,
    output logic [SIDE_W-1:0]              o_side
);

    // NR = 10/12/14 for 128/192/256-bit keys
    localparam int c_NR = KEY_BITS / 32 + 6;
    localparam int c_KW = 128 * (c_NR + 1);
    localparam int c_PW = N_LANES * 128 + N_LANES + c_KW + 3 + SIDE_W;

    localparam logic [1:0] c_EMPTY = 2'd0;
    localparam logic [1:0] c_ONE   = 2'd1;
    localparam logic [1:0] c_FULL  = 2'd2;

    generate
        if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key
            $error("aes_gcm_round_stage: KEY_BITS must be 128, 192 or 256");
        end
        if (FIRST_ROUND < 0 || ROUNDS < 1 || FIRST_ROUND + ROUNDS > c_NR + 1) begin : g_bad_rounds
            $error("aes_gcm_round_stage: round range outside 0..NR");
        end
        if (N_LANES < 1) begin : g_bad_lanes
            $error("aes_gcm_round_stage: N_LANES must be >= 1");
        end
    endgenerate

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box computed as x^254 (multiplicative inverse, 0 -> 0) then the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] v;
        p = a;
        v = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            v = gf_mul(v, p);
        end
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    // One AES round; state byte b sits at column b/4, row b%4
    function automatic logic [0:127] aes_round(input logic [0:127] s,
                                               input logic [0:127] k,
                                               input int r);
        logic [0:127] t;
        logic [0:127] u;
        logic [7:0]   a0, a1, a2, a3;
        if (r == 0) begin
            u = s;
        end else begin
            // SubBytes fused with ShiftRows: row rw of column c comes from column c+rw
            for (int b = 0; b < 16; b++)
                t[8*b +: 8] = sbox(s[8*(4*((b/4 + b%4) % 4) + b%4) +: 8]);
            u = t;
            if (r != c_NR) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[32*c      +: 8];
                    a1 = t[32*c + 8  +: 8];
                    a2 = t[32*c + 16 +: 8];
                    a3 = t[32*c + 24 +: 8];
                    u[32*c      +: 8] = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
                    u[32*c + 8  +: 8] = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
                    u[32*c + 16 +: 8] = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
                    u[32*c + 24 +: 8] = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);
                end
            end
        end
        return u ^ k;
    endfunction

    logic [0:N_LANES*128-1] w_proc;

    generate
        for (genvar l = 0; l < N_LANES; l++) begin : g_lane
            logic [0:127] w_rnd;
            // Chain the configured rounds over this lane's block
            always_comb begin
                w_rnd = i_block[128*l +: 128];
                for (int i = 0; i < ROUNDS; i++)
                    w_rnd = aes_round(w_rnd, i_key_schedule[128*(FIRST_ROUND+i) +: 128],
                                      FIRST_ROUND + i);
            end
            assign w_proc[128*l +: 128] = i_lane_en[l] ? w_rnd : i_block[128*l +: 128];
        end
    endgenerate

    logic [c_PW-1:0] w_in;
    logic [c_PW-1:0] r_or;
    logic [c_PW-1:0] r_sk;
    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic            r_ready;
    logic            w_accept;
    logic            w_drain;

    assign w_in     = {w_proc, i_lane_en, i_key_schedule, i_phase, i_side};
    assign w_accept = i_valid && r_ready;
    assign w_drain  = (r_state != c_EMPTY) && i_ready;
    assign o_valid  = (r_state != c_EMPTY);
    assign o_ready  = r_ready;
    assign {o_block, o_lane_en, o_key_schedule, o_phase, o_side} = r_or;

    // Occupancy next-state: OR holds the head beat, SK catches one more under stall
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_EMPTY: if (w_accept) w_state_nxt = c_ONE;
            c_ONE: begin
                if (w_accept && !w_drain)      w_state_nxt = c_FULL;
                else if (!w_accept && w_drain) w_state_nxt = c_EMPTY;
            end
            c_FULL:  if (w_drain) w_state_nxt = c_ONE;
            default: w_state_nxt = c_EMPTY;
        endcase
    end

    // State and registered ready; ready is low only while the skid entry is occupied
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_EMPTY;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt != c_FULL);
        end
    end

    // Payload movement between input, output register and skid entry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_or <= '0;
            r_sk <= '0;
        end else begin
            case (r_state)
                c_EMPTY: if (w_accept) r_or <= w_in;
                c_ONE: begin
                    if (w_accept && w_drain) r_or <= w_in;
                    else if (w_accept)       r_sk <= w_in;
                end
                c_FULL:  if (w_drain) r_or <= r_sk;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_gcm_round_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_gcm_round_stage
// Brief    : Self-checking bench for aes_gcm_round_stage: known-answer rounds
//            for AES-128/256, backpressure through the skid buffer, random
//            streaming against a byte-array AES model, and reset under stall.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_gcm_round_stage;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    // Full encryption stage (AES-128, rounds 0..10), three lanes
    logic             a_i_valid, a_o_ready, a_o_valid, a_i_ready;
    logic [0:383]     a_i_block, a_o_block;
    logic [2:0]       a_i_lane_en, a_o_lane_en;
    logic [0:1407]    a_i_ks, a_o_ks;
    logic [2:0]       a_i_phase, a_o_phase;
    logic [127:0]     a_i_side, a_o_side;

    // Single-round stage (AES-128, round 1 only)
    logic             b_i_valid, b_o_ready, b_o_valid, b_i_ready;
    logic [0:383]     b_i_block, b_o_block;
    logic [2:0]       b_i_lane_en, b_o_lane_en;
    logic [0:1407]    b_i_ks, b_o_ks;
    logic [2:0]       b_i_phase, b_o_phase;
    logic [127:0]     b_i_side, b_o_side;

    // Full encryption stage (AES-256, rounds 0..14), one lane
    logic             c_i_valid, c_o_ready, c_o_valid, c_i_ready;
    logic [0:127]     c_i_block, c_o_block;
    logic [0:0]       c_i_lane_en, c_o_lane_en;
    logic [0:1919]    c_i_ks, c_o_ks;
    logic [2:0]       c_i_phase, c_o_phase;
    logic [127:0]     c_i_side, c_o_side;

    aes_gcm_round_stage #(.N_LANES(3), .KEY_BITS(128), .FIRST_ROUND(0), .ROUNDS(11), .SIDE_W(128)) dut_a (
        .clk(clk), .rst(rst), .i_valid(a_i_valid), .o_ready(a_o_ready), .i_block(a_i_block),
        .i_lane_en(a_i_lane_en), .i_key_schedule(a_i_ks), .i_phase(a_i_phase), .i_side(a_i_side),
        .o_valid(a_o_valid), .i_ready(a_i_ready), .o_block(a_o_block), .o_lane_en(a_o_lane_en),
        .o_key_schedule(a_o_ks), .o_phase(a_o_phase), .o_side(a_o_side));

    aes_gcm_round_stage #(.N_LANES(3), .KEY_BITS(128), .FIRST_ROUND(1), .ROUNDS(1), .SIDE_W(128)) dut_b (
        .clk(clk), .rst(rst), .i_valid(b_i_valid), .o_ready(b_o_ready), .i_block(b_i_block),
        .i_lane_en(b_i_lane_en), .i_key_schedule(b_i_ks), .i_phase(b_i_phase), .i_side(b_i_side),
        .o_valid(b_o_valid), .i_ready(b_i_ready), .o_block(b_o_block), .o_lane_en(b_o_lane_en),
        .o_key_schedule(b_o_ks), .o_phase(b_o_phase), .o_side(b_o_side));

    aes_gcm_round_stage #(.N_LANES(1), .KEY_BITS(256), .FIRST_ROUND(0), .ROUNDS(15), .SIDE_W(128)) dut_c (
        .clk(clk), .rst(rst), .i_valid(c_i_valid), .o_ready(c_o_ready), .i_block(c_i_block),
        .i_lane_en(c_i_lane_en), .i_key_schedule(c_i_ks), .i_phase(c_i_phase), .i_side(c_i_side),
        .o_valid(c_o_valid), .i_ready(c_i_ready), .o_block(c_o_block), .o_lane_en(c_o_lane_en),
        .o_key_schedule(c_o_ks), .o_phase(c_o_phase), .o_side(c_o_side));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    logic [7:0] sb [256];

    typedef struct {
        logic [383:0]  blk;
        logic [2:0]    en;
        logic [2:0]    ph;
        logic [127:0]  sd;
        logic [0:1919] ks;
    } beat_t;

    beat_t sbq[$];

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box from log/antilog tables over generator 3 plus the bitwise affine map
    task automatic build_sbox();
        logic [7:0] alog [255];
        int         lg   [256];
        logic [7:0] x, inv, sv, c63;
        c63 = 8'h63;
        x = 8'h01;
        for (int i = 0; i < 255; i++) begin
            alog[i] = x;
            lg[x]   = i;
            x = x ^ xt(x);
        end
        for (int a = 0; a < 256; a++) begin
            inv = (a == 0) ? 8'h00 : alog[(255 - lg[a]) % 255];
            for (int b = 0; b < 8; b++)
                sv[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c63[b];
            sb[a] = sv;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    // FIPS-197 key expansion; key left-aligned in 256 bits, nk = 4 or 8 words
    function automatic logic [0:1919] expand_key(input logic [255:0] key, input int nk);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [0:1919] out;
        int            nw;
        nw  = 4 * (nk + 7);
        rc  = 8'h01;
        out = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < nw; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < nw; i++) out[32*i +: 32] = w[i];
        return out;
    endfunction

    // Rounds first..first+cnt-1 on a 4x4 byte matrix s[row][col]
    function automatic logic [127:0] model_rounds(input logic [127:0] blk, input logic [0:1919] ks,
                                                  input int first, input int cnt, input int nr);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [127:0] k, res;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[r][c] = blk[127-8*(4*c+r) -: 8];
        for (int rd = first; rd < first + cnt; rd++) begin
            k = ks[128*rd +: 128];
            if (rd != 0) begin
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++) t[r][c] = sb[s[r][(c+r)%4]];
                s = t;
                if (rd != nr) begin
                    for (int c = 0; c < 4; c++) begin
                        t[0][c] = xt(s[0][c]) ^ (xt(s[1][c]) ^ s[1][c]) ^ s[2][c] ^ s[3][c];
                        t[1][c] = s[0][c] ^ xt(s[1][c]) ^ (xt(s[2][c]) ^ s[2][c]) ^ s[3][c];
                        t[2][c] = s[0][c] ^ s[1][c] ^ xt(s[2][c]) ^ (xt(s[3][c]) ^ s[3][c]);
                        t[3][c] = (xt(s[0][c]) ^ s[0][c]) ^ s[1][c] ^ s[2][c] ^ xt(s[3][c]);
                    end
                    s = t;
                end
            end
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ k[127-8*(4*c+r) -: 8];
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) res[127-8*(4*c+r) -: 8] = s[r][c];
        return res;
    endfunction

    // Expected three-lane output of the full AES-128 stage
    function automatic logic [383:0] expect_a(input beat_t bt);
        logic [383:0] e;
        for (int l = 0; l < 3; l++)
            e[383-128*l -: 128] = bt.en[l] ? model_rounds(bt.blk[383-128*l -: 128], bt.ks, 0, 11, 10)
                                           : bt.blk[383-128*l -: 128];
        return e;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic rand_beat(output beat_t bt);
        logic [0:1919] ks;
        ks     = expand_key({rand128(), 128'h0}, 4);
        bt.blk = {rand128(), rand128(), rand128()};
        bt.en  = 3'($urandom_range(0, 7));
        bt.ph  = 3'($urandom_range(0, 7));
        bt.sd  = rand128();
        bt.ks  = ks;
    endtask

    task automatic drive_a(input beat_t bt);
        a_i_block   = bt.blk;
        a_i_lane_en = bt.en;
        a_i_phase   = bt.ph;
        a_i_side    = bt.sd;
        a_i_ks      = bt.ks[0:1407];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_vec++; if (a_o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", a_o_valid); end
        n_vec++; if (a_o_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_in_rst got %b want 0", a_o_ready); end
        n_vec++; if (a_o_block !== 384'h0) begin n_err++; $display("FAIL reset_block got %h want 0", a_o_block); end
        n_vec++; if ({a_o_lane_en, a_o_phase, a_o_side} !== 134'h0) begin
            n_err++; $display("FAIL reset_side got %h want 0", {a_o_lane_en, a_o_phase, a_o_side}); end
        n_vec++; if (a_o_ks !== 1408'h0) begin n_err++; $display("FAIL reset_keysched got %h want 0", a_o_ks[0:127]); end
        rst = 1'b0;
        tick();
        n_vec++; if (a_o_ready !== 1'b1 || a_o_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_release got ready=%b valid=%b want ready=1 valid=0", a_o_ready, a_o_valid); end
    endtask

    task automatic test_kat();
        logic [0:1919] ks;
        logic [127:0]  r1, r2, r3, r4, sd;
        ks = expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
        r1 = rand128(); r2 = rand128(); r3 = rand128(); r4 = rand128(); sd = rand128();
        a_i_block = {128'h00112233445566778899aabbccddeeff, r1, r2};
        a_i_lane_en = 3'b001; a_i_ks = ks[0:1407]; a_i_phase = 3'd2; a_i_side = sd;
        b_i_block = {128'h00102030405060708090a0b0c0d0e0f0, r3, r4};
        b_i_lane_en = 3'b001; b_i_ks = ks[0:1407]; b_i_phase = 3'd5; b_i_side = sd;
        ks = expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
        c_i_block = 128'h00112233445566778899aabbccddeeff; c_i_lane_en = 1'b1; c_i_ks = ks;
        c_i_phase = 3'd1; c_i_side = sd;
        a_i_valid = 1'b1; b_i_valid = 1'b1; c_i_valid = 1'b1;
        a_i_ready = 1'b1; b_i_ready = 1'b1; c_i_ready = 1'b1;
        tick();
        a_i_valid = 1'b0; b_i_valid = 1'b0; c_i_valid = 1'b0;
        n_vec++; if (a_o_valid !== 1'b1 || a_o_block[0:127] !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
            n_err++; $display("FAIL kat_aes128 got v=%b %h want 69c4e0d86a7b0430d8cdb78070b4c55a", a_o_valid, a_o_block[0:127]); end
        n_vec++; if (a_o_block[128:383] !== {r1, r2}) begin
            n_err++; $display("FAIL kat_passthrough got %h want %h", a_o_block[128:383], {r1, r2}); end
        n_vec++; if (b_o_valid !== 1'b1 || b_o_block[0:127] !== 128'h89d810e8855ace682d1843d8cb128fe4) begin
            n_err++; $display("FAIL kat_round1 got v=%b %h want 89d810e8855ace682d1843d8cb128fe4", b_o_valid, b_o_block[0:127]); end
        n_vec++; if (b_o_phase !== 3'd5 || b_o_side !== sd || b_o_lane_en !== 3'b001 || b_o_ks !== b_i_ks
                     || b_o_block[128:383] !== {r3, r4}) begin
            n_err++; $display("FAIL kat_forward got ph=%0d side=%h want ph=5 side=%h", b_o_phase, b_o_side, sd); end
        n_vec++; if (c_o_valid !== 1'b1 || c_o_block !== 128'h8ea2b7ca516745bfeafc49904b496089) begin
            n_err++; $display("FAIL kat_aes256 got v=%b %h want 8ea2b7ca516745bfeafc49904b496089", c_o_valid, c_o_block); end
        tick();
        n_vec++; if (a_o_valid !== 1'b0 || c_o_valid !== 1'b0) begin
            n_err++; $display("FAIL kat_drain got a=%b c=%b want 0 0", a_o_valid, c_o_valid); end
    endtask

    task automatic test_backpressure();
        beat_t bA, bB, bC;
        logic [383:0] eA, eB;
        rand_beat(bA); rand_beat(bB); rand_beat(bC);
        eA = expect_a(bA); eB = expect_a(bB);
        a_i_ready = 1'b0;
        drive_a(bA); a_i_valid = 1'b1;
        tick();
        drive_a(bB);
        tick();
        n_vec++; if (a_o_ready !== 1'b0 || a_o_valid !== 1'b1) begin
            n_err++; $display("FAIL bp_full got ready=%b valid=%b want 0 1", a_o_ready, a_o_valid); end
        drive_a(bC);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++; if (a_o_block !== eA || a_o_side !== bA.sd || a_o_ready !== 1'b0) begin
                n_err++; $display("FAIL bp_hold%0d got %h ready=%b want %h", i, a_o_block, a_o_ready, eA); end
        end
        a_i_valid = 1'b0;
        a_i_ready = 1'b1;
        n_vec++; if (a_o_block !== eA || a_o_valid !== 1'b1) begin
            n_err++; $display("FAIL bp_first got %h want %h", a_o_block, eA); end
        tick();
        n_vec++; if (a_o_block !== eB || a_o_valid !== 1'b1 || a_o_phase !== bB.ph || a_o_ready !== 1'b1) begin
            n_err++; $display("FAIL bp_second got %h ready=%b want %h ready=1", a_o_block, a_o_ready, eB); end
        tick();
        n_vec++; if (a_o_valid !== 1'b0 || a_o_ready !== 1'b1) begin
            n_err++; $display("FAIL bp_empty got valid=%b ready=%b want 0 1", a_o_valid, a_o_ready); end
    endtask

    task automatic test_stream();
        beat_t bt, ex;
        logic [383:0] e;
        a_i_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            rand_beat(bt);
            drive_a(bt);
            a_i_valid = 1'b1;
            sbq.push_back(bt);
            tick();
            n_vec++;
            if (a_o_valid !== 1'b1 || a_o_ready !== 1'b1 || sbq.size() == 0) begin
                n_err++; $display("FAIL stream%0d no output got valid=%b ready=%b want 1 1", i, a_o_valid, a_o_ready);
            end else begin
                ex = sbq.pop_front();
                e  = expect_a(ex);
                if (a_o_block !== e) begin
                    n_err++; $display("FAIL stream%0d block got %h want %h", i, a_o_block, e);
                end else if (a_o_lane_en !== ex.en || a_o_phase !== ex.ph || a_o_side !== ex.sd
                             || a_o_ks !== ex.ks[0:1407]) begin
                    n_err++; $display("FAIL stream%0d sideband got en=%b ph=%0d side=%h want en=%b ph=%0d side=%h",
                                      i, a_o_lane_en, a_o_phase, a_o_side, ex.en, ex.ph, ex.sd);
                end
            end
        end
        a_i_valid = 1'b0;
        tick();
        n_vec++; if (a_o_valid !== 1'b0 || sbq.size() != 0) begin
            n_err++; $display("FAIL stream_end got valid=%b pending=%0d want 0 0", a_o_valid, sbq.size()); end
    endtask

    task automatic test_reset_full();
        beat_t bA, bB, bC;
        logic [383:0] eC;
        rand_beat(bA); rand_beat(bB); rand_beat(bC);
        eC = expect_a(bC);
        a_i_ready = 1'b0;
        drive_a(bA); a_i_valid = 1'b1;
        tick();
        drive_a(bB);
        tick();
        n_vec++; if (a_o_ready !== 1'b0) begin n_err++; $display("FAIL rstfull_setup got ready=%b want 0", a_o_ready); end
        rst = 1'b1;
        drive_a(bC);
        tick();
        n_vec++; if (a_o_valid !== 1'b0 || a_o_ready !== 1'b0 || a_o_block !== 384'h0
                     || {a_o_lane_en, a_o_phase, a_o_side} !== 134'h0 || a_o_ks !== 1408'h0) begin
            n_err++; $display("FAIL rstfull_clear got valid=%b ready=%b blk=%h want 0 0 0", a_o_valid, a_o_ready, a_o_block); end
        rst = 1'b0;
        a_i_valid = 1'b0;
        a_i_ready = 1'b1;
        tick();
        n_vec++; if (a_o_ready !== 1'b1 || a_o_valid !== 1'b0) begin
            n_err++; $display("FAIL rstfull_release got ready=%b valid=%b want 1 0", a_o_ready, a_o_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (a_o_valid !== 1'b0) begin n_err++; $display("FAIL rstfull_stale%0d got valid=1 want 0", i); end
        end
        drive_a(bC); a_i_valid = 1'b1;
        tick();
        a_i_valid = 1'b0;
        n_vec++; if (a_o_valid !== 1'b1 || a_o_block !== eC) begin
            n_err++; $display("FAIL rstfull_resume got v=%b %h want %h", a_o_valid, a_o_block, eC); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        a_i_valid = 1'b0; a_i_ready = 1'b0; a_i_block = '0; a_i_lane_en = '0; a_i_ks = '0; a_i_phase = '0; a_i_side = '0;
        b_i_valid = 1'b0; b_i_ready = 1'b0; b_i_block = '0; b_i_lane_en = '0; b_i_ks = '0; b_i_phase = '0; b_i_side = '0;
        c_i_valid = 1'b0; c_i_ready = 1'b0; c_i_block = '0; c_i_lane_en = '0; c_i_ks = '0; c_i_phase = '0; c_i_side = '0;
        build_sbox();
        test_reset();
        test_kat();
        test_backpressure();
        test_stream();
        test_reset_full();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
